// File: rtl/oven_sequencer.sv
// oven_sequencer: central control FSM for the FPGA oven.
// Handles power-on, entry of the target temperature and the bake time,
// preheat, the timed bake and completion. It also owns the 1 s tick and the
// simulated oven temperature. Digit formatting and seven-segment decode are
// done downstream.
// Optional feature macro: DOOR_INTERLOCK_EN adds a door_open input. While the
// door is open, preheat and bake pause.
module oven_sequencer #(
    parameter int TICK_DIV  = 50_000_000,
    parameter int TEMP_MIN  = 60,
    parameter int TEMP_MAX  = 900,
    parameter int TEMP_STEP = 10,
    parameter int TIME_MAX  = 3600,
    parameter int TIME_STEP = 60,
    parameter int AMBIENT   = 60,
    parameter int HEAT_RATE = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        power_sw,
    input  logic        btn_up,
    input  logic        btn_dn,
    input  logic        btn_mode,
    input  logic        btn_start,
`ifdef DOOR_INTERLOCK_EN
    input  logic        door_open,
`endif
    output logic [2:0]  state,
    output logic [9:0]  target_temp,
    output logic [9:0]  cur_temp,
    output logic [11:0] time_left,
    output logic        disp_sel,
    output logic        heater_on,
    output logic        preheat_done,
    output logic        bake_done
);

    typedef enum logic [2:0] {
        S_OFF      = 3'd0,
        S_SET_TEMP = 3'd1,
        S_SET_TIME = 3'd2,
        S_PREHEAT  = 3'd3,
        S_BAKE     = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    // All value arithmetic is done 13 bits wide and signed, so that a step
    // below zero or above the maximum is visible before the clamp.
    localparam logic signed [12:0] K_TEMP_MIN  = 13'(TEMP_MIN);
    localparam logic signed [12:0] K_TEMP_MAX  = 13'(TEMP_MAX);
    localparam logic signed [12:0] K_TEMP_STEP = 13'(TEMP_STEP);
    localparam logic signed [12:0] K_TIME_MAX  = 13'(TIME_MAX);
    localparam logic signed [12:0] K_TIME_STEP = 13'(TIME_STEP);
    localparam logic signed [12:0] K_AMBIENT   = 13'(AMBIENT);
    localparam logic signed [12:0] K_HEAT_RATE = 13'(HEAT_RATE);

    state_t state_q;
    state_t state_n;

    logic [TW-1:0] tick_cnt;
    logic          tick;

    logic [3:0] btn_raw;
    logic [3:0] btn_s1;
    logic [3:0] btn_s2;
    logic [3:0] btn_prev;
    logic [3:0] press;
    logic       press_up;
    logic       press_dn;
    logic       press_mode;
    logic       press_start;
    logic       up_only;
    logic       dn_only;
    logic       paused;

    logic signed [12:0] tgt_c;
    logic signed [12:0] cur_c;
    logic signed [12:0] time_c;
    logic signed [12:0] tgt_n;
    logic signed [12:0] cur_n;
    logic signed [12:0] time_n;
    logic signed [12:0] cooled;
    logic signed [12:0] heated;
    logic signed [12:0] drift;
    logic signed [12:0] bake_time;
    logic               disp_n;
    logic               heater_n;

    assign tick = (tick_cnt == TICK_LAST);

    // The free-running tick divider emits a one-cycle pulse every TICK_DIV clocks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TW'(1);
        end
    end

    assign btn_raw = {btn_start, btn_mode, btn_dn, btn_up};

    // Two-flop synchroniser plus a delayed copy, used for rising-edge detection on the buttons.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_s1   <= '0;
            btn_s2   <= '0;
            btn_prev <= '0;
        end else begin
            btn_s1   <= btn_raw;
            btn_s2   <= btn_s1;
            btn_prev <= btn_s2;
        end
    end

    assign press       = btn_s2 & ~btn_prev;
    assign press_up    = press[0];
    assign press_dn    = press[1];
    assign press_mode  = press[2];
    assign press_start = press[3];
    assign up_only     = press_up & ~press_dn;
    assign dn_only     = press_dn & ~press_up;

`ifdef DOOR_INTERLOCK_EN
    logic door_s1;
    logic door_s2;

    // Synchronise the door switch. Its level pauses heating and the timer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            door_s1 <= 1'b0;
            door_s2 <= 1'b0;
        end else begin
            door_s1 <= door_open;
            door_s2 <= door_s1;
        end
    end

    assign paused = door_s2;
`else
    assign paused = 1'b0;
`endif

    assign tgt_c  = $signed({3'b000, target_temp});
    assign cur_c  = $signed({3'b000, cur_temp});
    assign time_c = $signed({1'b0, time_left});

    // Next state, next values and next status flags. Power-off overrides everything else.
    always_comb begin
        state_n  = state_q;
        tgt_n    = tgt_c;
        cur_n    = cur_c;
        time_n   = time_c;
        disp_n   = disp_sel;
        heater_n = 1'b0;

        cooled = cur_c;
        if (tick) begin
            cooled = cur_c - 13'sd1;
            if (cooled < K_AMBIENT) begin
                cooled = K_AMBIENT;
            end
        end

        heated = cur_c + K_HEAT_RATE;

        drift = cur_c - 13'sd1;
        if (drift < 13'sd0) begin
            drift = 13'sd0;
        end

        bake_time = time_c;
        if (tick && !paused) begin
            bake_time = bake_time - 13'sd1;
        end
        if (up_only) begin
            bake_time = bake_time + K_TIME_STEP;
        end else if (dn_only) begin
            bake_time = bake_time - K_TIME_STEP;
        end
        if (bake_time < 13'sd0) begin
            bake_time = 13'sd0;
        end else if (bake_time > K_TIME_MAX) begin
            bake_time = K_TIME_MAX;
        end

        if (!power_sw) begin
            state_n = S_OFF;
            time_n  = 13'sd0;
            cur_n   = cooled;
        end else begin
            case (state_q)
                S_OFF: begin
                    cur_n   = cooled;
                    state_n = S_SET_TEMP;
                end
                S_SET_TEMP: begin
                    cur_n = cooled;
                    if (press_start) begin
                        if (time_c > 13'sd0 && !paused) begin
                            state_n = S_PREHEAT;
                        end
                    end else if (press_mode) begin
                        state_n = S_SET_TIME;
                    end else if (up_only) begin
                        tgt_n = (tgt_c + K_TEMP_STEP > K_TEMP_MAX) ? K_TEMP_MAX : tgt_c + K_TEMP_STEP;
                    end else if (dn_only) begin
                        tgt_n = (tgt_c - K_TEMP_STEP < K_TEMP_MIN) ? K_TEMP_MIN : tgt_c - K_TEMP_STEP;
                    end
                end
                S_SET_TIME: begin
                    cur_n = cooled;
                    if (press_start) begin
                        if (time_c > 13'sd0 && !paused) begin
                            state_n = S_PREHEAT;
                        end
                    end else if (press_mode) begin
                        state_n = S_SET_TEMP;
                    end else if (up_only) begin
                        time_n = (time_c + K_TIME_STEP > K_TIME_MAX) ? K_TIME_MAX : time_c + K_TIME_STEP;
                    end else if (dn_only) begin
                        time_n = (time_c - K_TIME_STEP < 13'sd0) ? 13'sd0 : time_c - K_TIME_STEP;
                    end
                end
                S_PREHEAT: begin
                    if (press_mode) begin
                        disp_n = ~disp_sel;
                    end
                    if (tick) begin
                        if (paused) begin
                            cur_n = drift;
                        end else if (heated >= tgt_c) begin
                            cur_n   = tgt_c;
                            state_n = S_BAKE;
                        end else begin
                            cur_n = heated;
                        end
                    end
                end
                S_BAKE: begin
                    time_n = bake_time;
                    if (tick) begin
                        if (paused) begin
                            cur_n = drift;
                        end else if (cur_c < tgt_c) begin
                            cur_n = (heated > tgt_c) ? tgt_c : heated;
                        end else begin
                            cur_n = drift;
                        end
                    end
                    if (bake_time == 13'sd0) begin
                        state_n = S_DONE;
                    end
                end
                S_DONE: begin
                    cur_n = cooled;
                    if (press_start || press_mode) begin
                        state_n = S_SET_TEMP;
                        time_n  = 13'sd0;
                    end
                end
                default: begin
                    state_n = S_OFF;
                end
            endcase
        end

        if (state_n == S_SET_TEMP) begin
            disp_n = 1'b1;
        end else if (state_n == S_SET_TIME) begin
            disp_n = 1'b0;
        end

        if (state_n == S_PREHEAT) begin
            heater_n = !paused;
        end else if (state_n == S_BAKE) begin
            heater_n = !paused && (cur_n < tgt_n);
        end
    end

    // State register and registered outputs. Status flags track the new state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_OFF;
            target_temp  <= 10'd100;
            cur_temp     <= 10'(AMBIENT);
            time_left    <= 12'd0;
            disp_sel     <= 1'b0;
            heater_on    <= 1'b0;
            preheat_done <= 1'b0;
            bake_done    <= 1'b0;
        end else begin
            state_q      <= state_n;
            target_temp  <= tgt_n[9:0];
            cur_temp     <= cur_n[9:0];
            time_left    <= time_n[11:0];
            disp_sel     <= disp_n;
            heater_on    <= heater_n;
            preheat_done <= (state_n == S_BAKE);
            bake_done    <= (state_n == S_DONE);
        end
    end

    assign state = state_q;

endmodule
